conv_window_feeder: RTL and testbench

Streams a raster-order signed 8-bit feature map into two line buffers and builds a sliding 3x3 window. For each window it drives the 3x3 compute stage's `image_data0..8`, `select` and `add` inputs. It is the producer side of that interface and sits between the input pixel source and the convolution compute unit.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_window_feeder_if.sv | 39 +++
 rtl/conv_window_feeder_line_buffer.sv | 26 ++
 rtl/conv_window_feeder.sv | 192 +++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution window feeder.
// Pixel type, default width and feeder FSM encoding.
package conv_pkg;

    localparam int DEF_DATA_W = 8;

    typedef logic signed [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S1,
        S2,
        ADD
    } feed_state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel-in / window-out bundle between pixel source, feeder and compute stage.
// master = feeder side, slave = source/compute side.
interface conv_window_feeder_if #(
    parameter int DATA_W = 8
);
    logic signed [DATA_W-1:0] pix_in;
    logic                     pix_valid;
    logic                     pix_ready;
    logic signed [DATA_W-1:0] win0;
    logic signed [DATA_W-1:0] win1;
    logic signed [DATA_W-1:0] win2;
    logic signed [DATA_W-1:0] win3;
    logic signed [DATA_W-1:0] win4;
    logic signed [DATA_W-1:0] win5;
    logic signed [DATA_W-1:0] win6;
    logic signed [DATA_W-1:0] win7;
    logic signed [DATA_W-1:0] win8;
    logic [1:0]               select;
    logic                     add;
    logic                     win_valid;
    logic                     done;

    modport master (
        input  pix_in, pix_valid,
        output pix_ready,
        output win0, win1, win2, win3, win4,
        output win5, win6, win7, win8,
        output select, add, win_valid, done
    );

    modport slave (
        output pix_in, pix_valid,
        input  pix_ready,
        input  win0, win1, win2, win3, win4,
        input  win5, win6, win7, win8,
        input  select, add, win_valid, done
    );

endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// One raster line of delay: shift on en, output is the oldest entry.
// Contents are never cleared; the feeder's counters gate validity.
module line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] i_din,
    output logic signed [DATA_W-1:0] o_dout
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Builds sliding 3x3 windows from a raster pixel stream and sequences the compute stage.
// Optional CONV_FEEDER_STRIDE2_EN: only even row/col windows start a sequence.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic clk,
    input  logic rst,
    conv_window_feeder_if.master io_feed
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    feed_state_t r_state;
    feed_state_t w_next;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_last;

    logic signed [DATA_W-1:0] r_win [9];
    logic signed [DATA_W-1:0] w_lb0_out;
    logic signed [DATA_W-1:0] w_lb1_out;

    logic       w_accept;
    logic       w_col_end;
    logic       w_row_end;
    logic       w_last_pos;
    logic       w_complete;
    logic       w_start;
    logic       w_idle;
    logic [1:0] w_sel;
    logic       w_add;
    logic       w_wv;

    assign w_accept   = io_feed.pix_valid && io_feed.pix_ready;
    assign w_col_end  = r_col == CW'(IMG_W - 1);
    assign w_row_end  = r_row == RW'(IMG_H - 1);
    assign w_last_pos = w_col_end && w_row_end;
    assign w_complete = (r_row >= RW'(2)) && (r_col >= CW'(2));

`ifdef CONV_FEEDER_STRIDE2_EN
    assign w_start = w_accept && w_complete && !r_row[0] && !r_col[0];
`else
    assign w_start = w_accept && w_complete;
`endif

    line_buffer #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W)
    ) u_lb0 (
        .clk   (clk),
        .en    (w_accept),
        .i_din (io_feed.pix_in),
        .o_dout(w_lb0_out)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W)
    ) u_lb1 (
        .clk   (clk),
        .en    (w_accept),
        .i_din (w_lb0_out),
        .o_dout(w_lb1_out)
    );

    // Counters wrap to (0,0) after the last pixel so the next frame needs no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb1_out;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb0_out;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= io_feed.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else if (w_start) begin
            r_last <= w_last_pos;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_idle = 1'b0;
        w_sel  = 2'd0;
        w_add  = 1'b0;
        w_wv   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (w_start) begin
                    w_next = S0;
                end
            end
            S0: begin
                w_wv   = 1'b1;
                w_next = S1;
            end
            S1: begin
                w_wv   = 1'b1;
                w_sel  = 2'd1;
                w_next = S2;
            end
            S2: begin
                w_wv   = 1'b1;
                w_sel  = 2'd2;
                w_next = ADD;
            end
            ADD: begin
                w_wv   = 1'b1;
                w_sel  = 2'd2;
                w_add  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef CONV_FEEDER_STRIDE2_EN
    // Last pixel at an odd position never starts a sequence, so flag the frame end directly.
    logic r_done_nseq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_nseq <= 1'b0;
        end else begin
            r_done_nseq <= w_accept && w_last_pos && !w_start;
        end
    end

    assign io_feed.done = (w_add && r_last) || r_done_nseq;
`else
    assign io_feed.done = w_add && r_last;
`endif

    assign io_feed.pix_ready = w_idle && rst;
    assign io_feed.select    = w_sel;
    assign io_feed.add       = w_add;
    assign io_feed.win_valid = w_wv;

    assign io_feed.win0 = r_win[0];
    assign io_feed.win1 = r_win[1];
    assign io_feed.win2 = r_win[2];
    assign io_feed.win3 = r_win[3];
    assign io_feed.win4 = r_win[4];
    assign io_feed.win5 = r_win[5];
    assign io_feed.win6 = r_win[6];
    assign io_feed.win7 = r_win[7];
    assign io_feed.win8 = r_win[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder on 4x4 and 5x5 frames.
// Windows are predicted by direct 3x3 slicing of the frame array.
module tb_conv_window_feeder;
    import conv_pkg::*;

`ifdef CONV_FEEDER_STRIDE2_EN
    localparam bit S2 = 1'b1;
`else
    localparam bit S2 = 1'b0;
`endif

    typedef struct packed {
        logic       pv;
        logic [1:0] sel;
        logic       add;
        logic       wv;
        logic       rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_window_feeder_if #(.DATA_W(8)) if4 ();
    conv_window_feeder_if #(.DATA_W(8)) if5 ();

    conv_window_feeder #(
        .IMG_W (4),
        .IMG_H (4),
        .DATA_W(8)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .io_feed(if4.master)
    );

    conv_window_feeder #(
        .IMG_W (5),
        .IMG_H (5),
        .DATA_W(8)
    ) dut5 (
        .clk    (clk),
        .rst    (rst),
        .io_feed(if5.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [71:0] got4[$];
    logic [71:0] got5[$];
    int done4 = 0;
    int done4_noadd = 0;
    int done5 = 0;
    int done5_noadd = 0;

    pixel_t f4[$];
    pixel_t f5[$];
    logic [71:0] exp4[$];
    logic [71:0] exp5[$];
    vec_t tbl[5];

    function automatic logic [71:0] win4();
        return {if4.win0, if4.win1, if4.win2, if4.win3, if4.win4,
                if4.win5, if4.win6, if4.win7, if4.win8};
    endfunction

    function automatic logic [71:0] win5();
        return {if5.win0, if5.win1, if5.win2, if5.win3, if5.win4,
                if5.win5, if5.win6, if5.win7, if5.win8};
    endfunction

    function automatic logic [4:0] ctl4();
        return {if4.select, if4.add, if4.win_valid, if4.done};
    endfunction

    always @(negedge clk) begin
        if (if4.add) got4.push_back(win4());
        if (if4.done) begin
            done4++;
            if (!if4.add) done4_noadd++;
        end
        if (if5.add) got5.push_back(win5());
        if (if5.done) begin
            done5++;
            if (!if5.add) done5_noadd++;
        end
    end

    // Window whose bottom-right pixel is (r,c), top-left tap in the MSBs.
    function automatic logic [71:0] win_at(input pixel_t f[$], input int w,
                                           input int r, input int c);
        logic [71:0] v = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                v = {v[63:0], f[(r - 2 + dr) * w + c - 2 + dc]};
            end
        end
        return v;
    endfunction

    task automatic build_exp(input pixel_t f[$], input int w, input int h,
                             output logic [71:0] q[$]);
        q = {};
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                if (!S2 || (r % 2 == 0 && c % 2 == 0)) q.push_back(win_at(f, w, r, c));
            end
        end
    endtask

    function automatic int exp_noadd(input int w, input int h);
        return (S2 && (((h - 1) % 2) != 0 || ((w - 1) % 2) != 0)) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_frame(input string nm, input logic [71:0] got[$],
                             input logic [71:0] exp[$]);
        check_i({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_win%0d", nm, i), got[i], exp[i]);
        end
    endtask

    // Presents f4[a..b-1]; returns with the last pixel set up to be taken on the next edge.
    task automatic drive4(input int a, input int b, input int gap);
        int idx = a;
        int budget = 0;
        while (idx < b) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drive4_timeout: stuck at pixel %0d", idx);
                if4.pix_valid = 1'b0;
                break;
            end
            if (int'($urandom_range(99)) < gap) begin
                if4.pix_valid = 1'b0;
            end else begin
                if4.pix_valid = 1'b1;
                if4.pix_in    = f4[idx];
                if (if4.pix_ready) idx++;
            end
        end
    endtask

    task automatic finish4();
        @(negedge clk);
        if4.pix_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic all_zero(input string nm);
        check({nm, "_win4"}, win4(), '0);
        check({nm, "_ctl4"}, {67'd0, ctl4()}, '0);
        check_i({nm, "_rdy4"}, int'(if4.pix_ready), 0);
        check({nm, "_win5"}, win5(), '0);
        check_i({nm, "_rdy5"}, int'(if5.pix_ready), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [71:0] w1_const;
        logic [71:0] w5_const;
        int snap;
        int idx;
        int budget;

        tbl[0] = '{pv: 1'b1, sel: 2'd0, add: 1'b0, wv: 1'b1, rdy: 1'b0};
        tbl[1] = '{pv: 1'b1, sel: 2'd1, add: 1'b0, wv: 1'b1, rdy: 1'b0};
        tbl[2] = '{pv: 1'b1, sel: 2'd2, add: 1'b0, wv: 1'b1, rdy: 1'b0};
        tbl[3] = '{pv: 1'b1, sel: 2'd2, add: 1'b1, wv: 1'b1, rdy: 1'b0};
        tbl[4] = '{pv: 1'b0, sel: 2'd0, add: 1'b0, wv: 1'b0, rdy: 1'b1};
        w1_const = 72'h01_02_03_05_06_07_09_0a_0b;
        w5_const = 72'h01_02_03_06_07_08_0b_0c_0d;

        rst = 1'b0;
        if4.pix_valid = 1'b0;
        if4.pix_in    = '0;
        if5.pix_valid = 1'b0;
        if5.pix_in    = '0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b1;

        // Frame A: 1..16 back-to-back, cycle-level check of the first window
        f4 = {};
        for (int i = 0; i < 16; i++) f4.push_back(pixel_t'(i + 1));
        build_exp(f4, 4, 4, exp4);
        got4 = {};
        done4 = 0;
        done4_noadd = 0;
        drive4(0, 11, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_i($sformatf("cyc%0d_sel", k), int'(if4.select), int'(tbl[k].sel));
            check_i($sformatf("cyc%0d_add", k), int'(if4.add), int'(tbl[k].add));
            check_i($sformatf("cyc%0d_wv", k), int'(if4.win_valid), int'(tbl[k].wv));
            check_i($sformatf("cyc%0d_rdy", k), int'(if4.pix_ready), int'(tbl[k].rdy));
            if (k < 4) check($sformatf("cyc%0d_win", k), win4(), w1_const);
            if4.pix_valid = tbl[k].pv;
            if4.pix_in    = f4[11];
        end
        drive4(11, 16, 0);
        finish4();
        cmp_frame("frameA", got4, exp4);
        check_i("frameA_done", done4, 1);
        check_i("frameA_done_noadd", done4_noadd, exp_noadd(4, 4));

        // Frame B: same frame with random valid gaps
        got4 = {};
        done4 = 0;
        done4_noadd = 0;
        drive4(0, 16, 40);
        finish4();
        cmp_frame("frameB_gaps", got4, exp4);
        check_i("frameB_done", done4, 1);

        // Random frames with signed extremes planted in the first window
        for (int it = 0; it < 3; it++) begin
            f4 = {};
            for (int i = 0; i < 16; i++) f4.push_back(pixel_t'($urandom));
            f4[0]  = -8'sd128;
            f4[5]  = 8'sd127;
            f4[10] = -8'sd128;
            build_exp(f4, 4, 4, exp4);
            got4 = {};
            done4 = 0;
            drive4(0, 16, 25);
            finish4();
            cmp_frame($sformatf("rand%0d", it), got4, exp4);
            check_i($sformatf("rand%0d_done", it), done4, 1);
            if (got4.size() > 0) begin
                check($sformatf("rand%0d_min_w0", it), {64'd0, got4[0][71:64]}, 72'h80);
                check($sformatf("rand%0d_max_w4", it), {64'd0, got4[0][39:32]}, 72'h7f);
                check($sformatf("rand%0d_min_w8", it), {64'd0, got4[0][7:0]}, 72'h80);
            end else begin
                check_i($sformatf("rand%0d_has_win", it), 0, 1);
            end
        end

        // Reset in the middle of window 2, then resend the whole frame
        f4 = {};
        for (int i = 0; i < 16; i++) f4.push_back(pixel_t'(i + 1));
        build_exp(f4, 4, 4, exp4);
        got4 = {};
        done4 = 0;
        drive4(0, 12, 0);
        @(negedge clk);
        if4.pix_valid = 1'b0;
        @(negedge clk);
`ifndef CONV_FEEDER_STRIDE2_EN
        check_i("rst_pre_sel", int'(if4.select), 1);
`endif
        snap = got4.size();
        rst = 1'b0;
        #1;
        all_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            all_zero("rst_hold");
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_i("rst_no_stray_add", got4.size(), snap);
        check_i("rst_no_done", done4, 0);
        got4 = {};
        drive4(0, 16, 0);
        finish4();
        cmp_frame("after_rst", got4, exp4);
        check_i("after_rst_done", done4, 1);

        // 5x5 frame 1..25
        f5 = {};
        for (int i = 0; i < 25; i++) f5.push_back(pixel_t'(i + 1));
        build_exp(f5, 5, 5, exp5);
        got5 = {};
        done5 = 0;
        done5_noadd = 0;
        idx = 0;
        budget = 0;
        while (idx < 25 && budget < 2000) begin
            @(negedge clk);
            budget++;
            if5.pix_valid = 1'b1;
            if5.pix_in    = f5[idx];
            if (if5.pix_ready) idx++;
        end
        if (idx < 25) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drive5_timeout: stuck at pixel %0d", idx);
        end
        @(negedge clk);
        if5.pix_valid = 1'b0;
        repeat (8) @(negedge clk);
        cmp_frame("frame5", got5, exp5);
        check_i("frame5_seqs", got5.size(), S2 ? 4 : 9);
        if (got5.size() > 0) check("frame5_first", got5[0], w5_const);
        else check_i("frame5_has_win", 0, 1);
        check_i("frame5_done", done5, 1);
        check_i("frame5_done_noadd", done5_noadd, exp_noadd(5, 5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
